// File: rtl/pkg_rolhas.sv
// Shared types and default sizing for the cork-supply manager.
package pkg_rolhas;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_XFER = 2'b01,
      ST_LOAD = 2'b10
   } estado_t;

   localparam int DEF_MAIN_CAP  = 20;
   localparam int DEF_SEC_CAP   = 99;
   localparam int DEF_MIN_LEVEL = 5;
   localparam int DEF_XFER_QTY  = 15;

endpackage

// File: rtl/modulo_contador_updown_sat.sv
// Up/down counter that saturates at 0 and MAX; inc and dec together hold the count.
module modulo_contador_updown_sat
   import pkg_rolhas::*;
#(
   parameter int W   = 8,
   parameter int MAX = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         inc,
   input  logic         dec,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && !dec && (count_q < W'(MAX)))
         count_d = count_q + W'(1);
      else if (dec && !inc && (count_q != '0))
         count_d = count_q - W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: rtl/modulo_gerenciador_rolhas_param.sv
// Cork-supply manager: main buffer + reservoir, automatic batch transfer and operator loads.
// Optional BCD display outputs for the reservoir level are built when ROLHAS_BCD_EN is defined.
module modulo_gerenciador_rolhas_param
   import pkg_rolhas::*;
#(
   parameter int  MAIN_CAP  = DEF_MAIN_CAP,
   parameter int  SEC_CAP   = DEF_SEC_CAP,
   parameter int  MIN_LEVEL = DEF_MIN_LEVEL,
   parameter int  XFER_QTY  = DEF_XFER_QTY,
   localparam int MAIN_W    = $clog2(MAIN_CAP+1),
   localparam int SEC_W     = $clog2(SEC_CAP+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              seal,
   input  logic              op_load,
   input  logic [SEC_W-1:0]  op_qty,
   output logic [MAIN_W-1:0] main_level,
   output logic [SEC_W-1:0]  sec_level,
   output logic [1:0]        state,
   output logic              ro,
   output logic              main_low,
   output logic              load_reject,
   output logic              busy,
   output logic [3:0]        sec_dez,
   output logic [3:0]        sec_uni
);

   localparam int XW = $clog2(XFER_QTY+1);

   if ((MIN_LEVEL + XFER_QTY > MAIN_CAP) || (XFER_QTY > SEC_CAP) || (XFER_QTY < 1)) begin : g_param_chk
      $error("XFER_QTY/MIN_LEVEL do not fit the buffer capacities");
   end

   estado_t          state_q, state_d;
   logic [XW-1:0]    xfer_rem_q, xfer_rem_d;
   logic [SEC_W-1:0] load_rem_q, load_rem_d;
   logic [SEC_W-1:0] pend_qty_q, pend_qty_d;
   logic             pend_q, pend_d;
   logic             load_reject_q, load_reject_d;
   logic             busy_q, busy_d;
   logic             main_inc, main_dec, sec_inc, sec_dec;
   logic [SEC_W:0]   soma;
   logic             recusa;

   // A second load cannot queue behind a pending or running one.
   assign soma   = {1'b0, sec_level} + {1'b0, op_qty};
   assign recusa = pend_q || (state_q == ST_LOAD) || (soma > (SEC_W+1)'(SEC_CAP));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         xfer_rem_q    <= '0;
         load_rem_q    <= '0;
         pend_qty_q    <= '0;
         pend_q        <= 1'b0;
         load_reject_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         xfer_rem_q    <= xfer_rem_d;
         load_rem_q    <= load_rem_d;
         pend_qty_q    <= pend_qty_d;
         pend_q        <= pend_d;
         load_reject_q <= load_reject_d;
         busy_q        <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      xfer_rem_d = xfer_rem_q;
      load_rem_d = load_rem_q;
      pend_d     = pend_q;
      pend_qty_d = pend_qty_q;
      if (enable) begin
         case (state_q)
            ST_IDLE: begin
               if (main_low && (sec_level >= SEC_W'(XFER_QTY))) begin
                  state_d    = ST_XFER;
                  xfer_rem_d = XW'(XFER_QTY);
               end else if (pend_q) begin
                  state_d    = ST_LOAD;
                  load_rem_d = pend_qty_q;
                  pend_d     = 1'b0;
               end
            end
            ST_XFER: begin
               xfer_rem_d = xfer_rem_q - XW'(1);
               if (xfer_rem_q == XW'(1)) state_d = ST_IDLE;
            end
            ST_LOAD: begin
               load_rem_d = load_rem_q - SEC_W'(1);
               if (load_rem_q == SEC_W'(1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
      // Acceptance ignores enable so the operator can stage a load while the line is stopped.
      if (op_load && (op_qty != '0) && !recusa) begin
         pend_d     = 1'b1;
         pend_qty_d = op_qty;
      end
   end

   always_comb begin
      main_inc      = enable && (state_q == ST_XFER);
      main_dec      = enable && seal && (main_level != '0);
      sec_inc       = enable && (state_q == ST_LOAD);
      sec_dec       = enable && (state_q == ST_XFER);
      load_reject_d = op_load && (op_qty != '0) && recusa;
      busy_d        = (state_d != ST_IDLE) || pend_d;
   end

   modulo_contador_updown_sat #(.W(MAIN_W), .MAX(MAIN_CAP)) u_main (
      .clk   (clk),
      .rst   (rst),
      .inc   (main_inc),
      .dec   (main_dec),
      .count (main_level)
   );

   modulo_contador_updown_sat #(.W(SEC_W), .MAX(SEC_CAP)) u_sec (
      .clk   (clk),
      .rst   (rst),
      .inc   (sec_inc),
      .dec   (sec_dec),
      .count (sec_level)
   );

   assign state       = state_q;
   assign load_reject = load_reject_q;
   assign busy        = busy_q;
   assign ro          = (main_level == '0);
   assign main_low    = (main_level <= MAIN_W'(MIN_LEVEL));

`ifdef ROLHAS_BCD_EN
   logic [3:0] sec_dez_q, sec_dez_d, sec_uni_q, sec_uni_d;

   always_comb begin
      if (int'(sec_level) > 99) begin
         sec_dez_d = 4'd9;
         sec_uni_d = 4'd9;
      end else begin
         sec_dez_d = 4'(int'(sec_level) / 10);
         sec_uni_d = 4'(int'(sec_level) % 10);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sec_dez_q <= '0;
         sec_uni_q <= '0;
      end else begin
         sec_dez_q <= sec_dez_d;
         sec_uni_q <= sec_uni_d;
      end
   end

   assign sec_dez = sec_dez_q;
   assign sec_uni = sec_uni_q;
`else
   assign sec_dez = '0;
   assign sec_uni = '0;
`endif

endmodule

// File: tb/tb_modulo_gerenciador_rolhas_param.sv
// Scoreboard bench for the cork-supply manager, walking the main line scenarios end to end.
module tb_modulo_gerenciador_rolhas_param;

   localparam int MAIN_CAP = 20;
   localparam int SEC_CAP  = 99;
   localparam int MAIN_W   = $clog2(MAIN_CAP+1);
   localparam int SEC_W    = $clog2(SEC_CAP+1);
   localparam logic [1:0] IDLE = 2'b00, XFER = 2'b01, LOAD = 2'b10;

   logic              clk = 1'b0;
   logic              rst, enable, seal, op_load;
   logic [SEC_W-1:0]  op_qty;
   logic [MAIN_W-1:0] main_level;
   logic [SEC_W-1:0]  sec_level;
   logic [1:0]        state;
   logic              ro, main_low, load_reject, busy;
   logic [3:0]        sec_dez, sec_uni;

   modulo_gerenciador_rolhas_param dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .seal        (seal),
      .op_load     (op_load),
      .op_qty      (op_qty),
      .main_level  (main_level),
      .sec_level   (sec_level),
      .state       (state),
      .ro          (ro),
      .main_low    (main_low),
      .load_reject (load_reject),
      .busy        (busy),
      .sec_dez     (sec_dez),
      .sec_uni     (sec_uni)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (!rst) assert ((int'(main_level) <= MAIN_CAP) && (int'(sec_level) <= SEC_CAP))
         else $error("counter above capacity");
   end

   typedef enum int {SG_MAIN, SG_SEC, SG_EST, SG_RO, SG_LOW, SG_REJ, SG_BUSY, SG_DEZ, SG_UNI} sinal_t;
   typedef struct {
      string  tag;
      sinal_t sg;
      int     esp;
   } item_t;

   item_t fila[$];
   int    n_chk = 0;
   int    n_ok  = 0;

   task automatic checa(input string tag, input int obs, input int esp);
      n_chk++;
      if (obs == esp) n_ok++;
      else $display("FAIL %s: got %0d, expected %0d", tag, obs, esp);
   endtask

   function automatic int le(input sinal_t sg);
      case (sg)
         SG_MAIN: return int'(main_level);
         SG_SEC:  return int'(sec_level);
         SG_EST:  return int'(state);
         SG_RO:   return int'(ro);
         SG_LOW:  return int'(main_low);
         SG_REJ:  return int'(load_reject);
         SG_BUSY: return int'(busy);
         SG_DEZ:  return int'(sec_dez);
         default: return int'(sec_uni);
      endcase
   endfunction

   task automatic espera(input string tag, input sinal_t sg, input int esp);
      item_t it;
      it.tag = tag; it.sg = sg; it.esp = esp;
      fila.push_back(it);
   endtask

   task automatic drena();
      item_t it;
      while (fila.size() > 0) begin
         it = fila.pop_front();
         checa(it.tag, le(it.sg), it.esp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulso_load(input int q);
      op_load = 1'b1;
      op_qty  = SEC_W'(q);
      tick();
      op_load = 1'b0;
      op_qty  = '0;
   endtask

   task automatic sela(input int n);
      seal = 1'b1;
      repeat (n) tick();
      seal = 1'b0;
   endtask

   task automatic aguarda(input logic [1:0] st);
      int w = 0;
      while (state != st && w < 300) begin tick(); w++; end
   endtask

   // n = cycles spent in st (waiting for it first), -1 if st never shows up.
   task automatic conta(input logic [1:0] st, output int n);
      aguarda(st);
      n = -1;
      if (state == st) begin
         n = 0;
         while (state == st && n < 300) begin tick(); n++; end
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; enable = 1'b0; seal = 1'b0; op_load = 1'b0; op_qty = '0;
      repeat (3) tick();
      espera("rst_main", SG_MAIN, 0);  espera("rst_sec", SG_SEC, 0);
      espera("rst_state", SG_EST, 0);  espera("rst_ro", SG_RO, 1);
      espera("rst_low", SG_LOW, 1);    espera("rst_busy", SG_BUSY, 0);
      espera("rst_rej", SG_REJ, 0);
      drena();

      rst = 1'b0; enable = 1'b1;
      tick();

      // first fill: load 40 then automatic transfer of 15
      pulso_load(40);
      espera("load40_rej", SG_REJ, 0); espera("load40_busy", SG_BUSY, 1);
      drena();
      conta(LOAD, n); checa("load40_cycles", n, 40);
      espera("load40_sec", SG_SEC, 40); drena();
      conta(XFER, n); checa("xfer1_cycles", n, 15);
      espera("xfer1_main", SG_MAIN, 15); espera("xfer1_sec", SG_SEC, 25);
      espera("xfer1_ro", SG_RO, 0);      espera("xfer1_low", SG_LOW, 0);
      drena();

      // seal down to the threshold
      sela(9);
      espera("seal9_main", SG_MAIN, 6); espera("seal9_low", SG_LOW, 0); drena();
      sela(1);
      espera("thr_main", SG_MAIN, 5); espera("thr_low", SG_LOW, 1);
      espera("thr_state", SG_EST, 0); drena();
      tick();
      espera("thr_xfer_start", SG_EST, 1); drena();
      conta(XFER, n); checa("xfer2_cycles", n, 15);
      espera("xfer2_main", SG_MAIN, 20); espera("xfer2_sec", SG_SEC, 10); drena();

      // seals during the whole transfer hold main_level
      pulso_load(40);
      conta(LOAD, n); checa("load40b_cycles", n, 40);
      sela(15);
      espera("pre_seal_main", SG_MAIN, 5); drena();
      aguarda(XFER);
      seal = 1'b1;
      n = 0;
      while (state == XFER && n < 300) begin
         tick(); n++;
         espera("xfer_seal_main", SG_MAIN, 5); drena();
      end
      seal = 1'b0;
      checa("xfer_seal_cycles", n, 15);
      espera("xfer_seal_sec", SG_SEC, 35); drena();
      conta(XFER, n); checa("xfer3_cycles", n, 15);
      espera("xfer3_main", SG_MAIN, 20); espera("xfer3_sec", SG_SEC, 20); drena();

      // reservoir capacity limit
      pulso_load(70);
      conta(LOAD, n); checa("load70_cycles", n, 70);
      espera("load70_sec", SG_SEC, 90); drena();
      pulso_load(10);
      espera("over_rej", SG_REJ, 1); espera("over_sec", SG_SEC, 90); drena();
      tick();
      espera("over_rej_clr", SG_REJ, 0); espera("over_busy", SG_BUSY, 0);
      espera("over_state", SG_EST, 0);   espera("over_sec2", SG_SEC, 90); drena();
      pulso_load(9);
      espera("fit_rej", SG_REJ, 0); drena();
      tick();
      espera("fit_state", SG_EST, 2); drena();
      pulso_load(1);
      espera("inload_rej", SG_REJ, 1); drena();
      conta(LOAD, n); checa("fit_rest_cycles", n, 8);
      espera("fit_sec", SG_SEC, 99); drena();
      tick();
`ifdef ROLHAS_BCD_EN
      espera("bcd_dez", SG_DEZ, 9); espera("bcd_uni", SG_UNI, 9);
`else
      espera("bcd_dez", SG_DEZ, 0); espera("bcd_uni", SG_UNI, 0);
`endif
      drena();

      // load requested during transfer starts right after it
      sela(15);
      aguarda(XFER);
      repeat (5) tick();
      espera("mid_xfer_sec", SG_SEC, 94); drena();
      pulso_load(5);
      espera("xferload_rej", SG_REJ, 0); espera("xferload_busy", SG_BUSY, 1); drena();
      aguarda(IDLE);
      espera("after_xfer_state", SG_EST, 0); drena();
      tick();
      espera("pend_load_state", SG_EST, 2); drena();
      conta(LOAD, n); checa("pend_load_cycles", n, 5);
      espera("pend_main", SG_MAIN, 20); espera("pend_sec", SG_SEC, 89); drena();

      // freeze mid-transfer with 8 corks left to move
      sela(15);
      aguarda(XFER);
      repeat (7) tick();
      enable = 1'b0; seal = 1'b1;
      pulso_load(3);
      repeat (6) tick();
      espera("frz_rej", SG_REJ, 0);    espera("frz_busy", SG_BUSY, 1);
      espera("frz_main", SG_MAIN, 12); espera("frz_sec", SG_SEC, 82);
      espera("frz_state", SG_EST, 1);  drena();
      seal = 1'b0; enable = 1'b1;
      conta(XFER, n); checa("resume_cycles", n, 8);
      espera("resume_main", SG_MAIN, 20); espera("resume_sec", SG_SEC, 74); drena();
      conta(LOAD, n); checa("frz_load_cycles", n, 3);
      espera("frz_load_sec", SG_SEC, 77); drena();

      // reset in the middle of a load
      pulso_load(20);
      aguarda(LOAD);
      repeat (5) tick();
      rst = 1'b1;
      #1;
      espera("arst_main", SG_MAIN, 0); espera("arst_sec", SG_SEC, 0);
      espera("arst_state", SG_EST, 0); espera("arst_ro", SG_RO, 1);
      espera("arst_busy", SG_BUSY, 0); drena();
      tick();
      rst = 1'b0;
      tick();
      espera("post_rst_state", SG_EST, 0); espera("post_rst_sec", SG_SEC, 0); drena();

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
